bfp_comp_pkt_fifo: RTL and testbench
====================================

BFP_COMP_PKT_FIFO -- requirements
Module: bfp_comp_pkt_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 512: data FIFO depth in 64-bit words, power of two, minimum 16.
REQ-002 The block SHALL have parameter PKT_DEPTH, default 16: maximum committed packets held, power of two.
REQ-003 The block SHALL have port clk, input, 1: sole clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have ports s_axis_tdata, tkeep, tvalid, tlast, tuser, inputs, widths 64/8/1/1/32: push-only stream from the BFP compressor, with no tready.
REQ-006 The block SHALL have ports m_axis_tdata, tkeep, tvalid, tlast, tuser, outputs, widths 64/8/1/1/32: stored packets out.
REQ-007 The block SHALL have port m_axis_tready, input, 1: downstream backpressure.
REQ-008 The block SHALL have port stat_drop_cnt, output, 16: dropped-packet count, saturating at 0xFFFF.
REQ-009 The block SHALL have port stat_overflow, output, 1: one-cycle pulse per dropped packet.
REQ-010 The block SHALL have port stat_level, output, log2(DEPTH)+1: words held, committed plus in-progress.

Function
REQ-011 Beat: s_axis_tvalid=1; the first beat after reset or after a tlast beat SHALL be a packet start.
REQ-012 tuser SHALL be sampled only on the packet-start beat and held with the packet.
REQ-013 Write FSM SHALL have two states: ACCEPT and DROP.
REQ-014 ACCEPT, beat with free space ≥1, and (not start or packet FIFO not full): word SHALL be written at wr_ptr; wr_ptr SHALL increment.
REQ-015 ACCEPT, written beat with tlast=1: wr_commit SHALL become wr_ptr+1, and tuser SHALL be pushed to the packet FIFO in the same cycle.
REQ-016 ACCEPT, beat with free space 0, or start with packet FIFO full: wr_ptr SHALL revert to wr_commit; stat_drop_cnt SHALL increment; stat_overflow SHALL pulse next cycle; next state SHALL be DROP unless the beat has tlast=1, in which case the state SHALL stay ACCEPT.
REQ-017 DROP SHALL discard beats up to and including tlast, then return to ACCEPT; no further counting SHALL occur for the same packet.
REQ-018 Free space SHALL be DEPTH-(wr_ptr-rd_ptr), using pointers one bit wider than the address and registered values; a read in cycle N SHALL free space from cycle N+1.
REQ-019 Store-and-forward: no word of a packet SHALL appear on m_axis before its tlast beat is committed.
REQ-020 m_axis_tvalid SHALL assert when words exist between rd_ptr and wr_commit, through a first-word-fall-through output register over 1-cycle-latency RAM.
REQ-021 Latency, empty FIFO: tlast beat written in cycle N SHALL give first word valid in cycle N+3.
REQ-022 With tready held at 1, the block SHALL then stream 1 word/cycle with no bubbles, including across packet boundaries.
REQ-023 When m_axis_tvalid=1 and m_axis_tready=0, all m_axis outputs SHALL hold stable.
REQ-024 m_axis_tuser SHALL equal the packet-FIFO head for every word of the packet; the head SHALL pop on the tlast handshake.
REQ-025 m_axis_tkeep and m_axis_tlast SHALL be passed through unaltered from the stored word.
REQ-026 Commit, read and drop in the same cycle SHALL all take effect without loss.
REQ-027 Pointer wrap-around SHALL be seamless.
REQ-028 A packet longer than DEPTH words SHALL always be dropped.

Reset
REQ-029 While rst_n=0, all outputs SHALL be 0, all pointers SHALL be 0, the FSM SHALL be in ACCEPT, and the packet FIFO SHALL be empty.
REQ-030 Reset mid-packet SHALL discard uncommitted words and any partially read packet.
REQ-031 After reset, the first beat SHALL be treated as a packet start.
REQ-032 RAM contents SHALL NOT require reset.

Verification
REQ-033 DEPTH=16: 4-word packet, tuser=0xA5A5_0001, tready=1 -> words appear cycles N+3..N+6 in order; tlast on word 4; tuser constant; stat_level returns to 0.
REQ-034 tready=0 and 20-word packet into DEPTH=16 -> packet dropped; stat_drop_cnt=1; one stat_overflow pulse; stat_level=0 after tlast; next 3-word packet accepted intact.
REQ-035 Three 5-word packets with tready=0 into DEPTH=16 -> first three packets stored (15 words); a fourth 2-word packet is dropped; release tready -> 15 words out back-to-back with correct tuser per packet.
REQ-036 PKT_DEPTH=2: three 1-word packets with tready=0 -> third dropped; drop count 1.
REQ-037 Random tready at 50%, 1000 packets of 1-40 words -> no loss or reorder; outputs stable under stall; drop count 0 when DEPTH ≥ 64.
REQ-038 rst_n low mid-packet with 2 words written, then a 3-word packet -> only the 3-word packet is output; stat_drop_cnt=0.

Source files
------------

// File: rtl/bfp_comp_pkt_fifo.sv
// bfp_comp_pkt_fifo
//   Store-and-forward packet FIFO behind the BFP compressor. The input stream
//   is push-only (no tready). A packet is made visible downstream only after
//   its tlast beat has been written. A packet that cannot fit is dropped as a
//   whole and counted. Each packet carries one tuser word, captured on its
//   first beat and replayed on every output word of that packet.
// Ports
//   clk, rst_n                  : clock, asynchronous active-low reset
//   s_axis_*                    : input stream (tdata/tkeep/tvalid/tlast/tuser)
//   m_axis_*, m_axis_tready     : output stream with backpressure
//   stat_drop_cnt               : dropped-packet count, saturates at 0xFFFF
//   stat_overflow               : one-cycle pulse per dropped packet
//   stat_level                  : words held (committed plus in-progress)
module bfp_comp_pkt_fifo #(
  parameter int DEPTH     = 512,
  parameter int PKT_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [63:0]               s_axis_tdata,
  input  logic [7:0]                s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  input  logic [31:0]               s_axis_tuser,
  output logic [63:0]               m_axis_tdata,
  output logic [7:0]                m_axis_tkeep,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  output logic [31:0]               m_axis_tuser,
  input  logic                      m_axis_tready,
  output logic [15:0]               stat_drop_cnt,
  output logic                      stat_overflow,
  output logic [$clog2(DEPTH):0]    stat_level
);
  localparam int AW  = $clog2(DEPTH);
  localparam int PAW = (PKT_DEPTH > 1) ? $clog2(PKT_DEPTH) : 1;
  localparam logic [AW:0]  FULL_LVL = DEPTH[AW:0];
  localparam logic [PAW:0] PKT_FULL = PKT_DEPTH[PAW:0];

  typedef enum logic {ACCEPT, DROP} wr_state_t;

  wr_state_t   state_q, state_d;
  logic        in_pkt_q, in_pkt_d;
  logic [31:0] tuser_q, tuser_d;
  // rd_ptr counts words consumed downstream; fetch_ptr addresses the RAM and
  // runs up to two words ahead to feed the output stage.
  logic [AW:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d, fetch_ptr_q, fetch_ptr_d;
  logic [PAW:0] pkt_wr_q, pkt_wr_d, pkt_rd_q, pkt_rd_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        overflow_q, overflow_d;
  logic        rd_pend_q, rd_pend_d;
  logic        out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [72:0] out_word_q, out_word_d, skid_word_q, skid_word_d;
  logic [72:0] ram_rdata_q;

  logic [72:0] mem [DEPTH];
  logic [31:0] pkt_mem [2**PAW];

  logic        ram_we, pkt_push, fetch_en, pop, is_start, free_zero, pkt_full;
  logic [31:0] pkt_push_val;
  logic [1:0]  occ, occ_after;

  assign is_start  = !in_pkt_q;
  assign free_zero = ((wr_ptr_q - rd_ptr_q) == FULL_LVL);
  assign pkt_full  = ((pkt_wr_q - pkt_rd_q) == PKT_FULL);

  // Write side: ACCEPT/DROP state machine.
  always_comb begin
    state_d      = state_q;
    in_pkt_d     = in_pkt_q;
    tuser_d      = tuser_q;
    wr_ptr_d     = wr_ptr_q;
    wr_commit_d  = wr_commit_q;
    pkt_wr_d     = pkt_wr_q;
    drop_cnt_d   = drop_cnt_q;
    overflow_d   = 1'b0;
    ram_we       = 1'b0;
    pkt_push     = 1'b0;
    pkt_push_val = is_start ? s_axis_tuser : tuser_q;
    if (s_axis_tvalid) begin
      in_pkt_d = !s_axis_tlast;
      if (state_q == ACCEPT) begin
        if (!free_zero && !(is_start && pkt_full)) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (is_start) tuser_d = s_axis_tuser;
          if (s_axis_tlast) begin
            wr_commit_d = wr_ptr_q + 1'b1;
            pkt_push    = 1'b1;
            pkt_wr_d    = pkt_wr_q + 1'b1;
          end
        end else begin
          // Roll back the partial packet; a drop on its tlast beat needs no
          // DROP phase since the packet is already over.
          wr_ptr_d   = wr_commit_q;
          overflow_d = 1'b1;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 1'b1;
          if (!s_axis_tlast) state_d = DROP;
        end
      end else if (s_axis_tlast) begin
        state_d = ACCEPT;
      end
    end
  end

  // Read side: RAM read feeds a two-entry (output + skid) stage so that a
  // fetch can be issued every cycle despite the one-cycle RAM latency.
  assign pop       = out_valid_q && m_axis_tready;
  assign occ       = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pend_q};
  assign occ_after = occ - {1'b0, pop};
  assign fetch_en  = (fetch_ptr_q != wr_commit_q) && (occ_after < 2'd2);

  always_comb begin
    rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, pop};
    fetch_ptr_d  = fetch_ptr_q + {{AW{1'b0}}, fetch_en};
    rd_pend_d    = fetch_en;
    pkt_rd_d     = pkt_rd_q + {{PAW{1'b0}}, (pop && out_word_q[0])};
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    skid_valid_d = skid_valid_q;
    skid_word_d  = skid_word_q;
    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_word_d   = skid_word_q;
        skid_valid_d = rd_pend_q;
        if (rd_pend_q) skid_word_d = ram_rdata_q;
      end else begin
        out_valid_d = rd_pend_q;
        if (rd_pend_q) out_word_d = ram_rdata_q;
      end
    end else if (rd_pend_q) begin
      skid_valid_d = 1'b1;
      skid_word_d  = ram_rdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCEPT;
      in_pkt_q     <= 1'b0;
      tuser_q      <= '0;
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      rd_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      pkt_wr_q     <= '0;
      pkt_rd_q     <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      rd_pend_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_word_q  <= '0;
    end else begin
      state_q      <= state_d;
      in_pkt_q     <= in_pkt_d;
      tuser_q      <= tuser_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      pkt_wr_q     <= pkt_wr_d;
      pkt_rd_q     <= pkt_rd_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
      rd_pend_q    <= rd_pend_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      skid_valid_q <= skid_valid_d;
      skid_word_q  <= skid_word_d;
    end
  end

  // Storage arrays carry no reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_ptr_q[AW-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    if (fetch_en) ram_rdata_q <= mem[fetch_ptr_q[AW-1:0]];
    if (pkt_push) pkt_mem[pkt_wr_q[PAW-1:0]] <= pkt_push_val;
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_word_q[72:9];
  assign m_axis_tkeep  = out_word_q[8:1];
  assign m_axis_tlast  = out_word_q[0];
  assign m_axis_tuser  = out_valid_q ? pkt_mem[pkt_rd_q[PAW-1:0]] : 32'd0;
  assign stat_drop_cnt = drop_cnt_q;
  assign stat_overflow = overflow_q;
  assign stat_level    = wr_ptr_q - rd_ptr_q;
endmodule

// File: tb/tb_bfp_comp_pkt_fifo.sv
// Directed bench for bfp_comp_pkt_fifo (DEPTH=16, PKT_DEPTH=4). Stimulus
// pushes the words it expects to see into a scoreboard queue; an independent
// monitor pops and compares on every output handshake and also checks that
// the outputs hold while stalled.
module tb_bfp_comp_pkt_fifo;
  localparam int DEPTH     = 16;
  localparam int PKT_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid, s_tlast;
  logic [31:0] s_tuser;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid, m_tlast, m_tready;
  logic [31:0] m_tuser;
  logic [15:0] drop_cnt;
  logic        ovf;
  logic [4:0]  level;

  bfp_comp_pkt_fifo #(.DEPTH(DEPTH), .PKT_DEPTH(PKT_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .stat_drop_cnt(drop_cnt), .stat_overflow(ovf), .stat_level(level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [31:0] u;
  } word_t;

  word_t sb[$];
  int    hs_cyc[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    ovf_pulses = 0;
  int    last_cyc = 0;
  bit    prev_stall = 0;
  word_t prev_word;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    word_t cur, exp;
    cur = '{d: m_tdata, k: m_tkeep, l: m_tlast, u: m_tuser};
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!m_tvalid || cur != prev_word) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d actual=%h valid=%0b required=%h valid=1",
                   cyc, cur, m_tvalid, prev_word);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word cyc=%0d actual=%h required=none", cyc, cur);
        end else begin
          exp = sb.pop_front();
          if (cur != exp) begin
            errors++;
            $display("FAIL out_word cyc=%0d actual=%h required=%h", cyc, cur, exp);
          end else begin
            $display("out cyc=%0d data=%h keep=%h last=%0b user=%h",
                     cyc, cur.d, cur.k, cur.l, cur.u);
          end
        end
        hs_cyc.push_back(cyc);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_word  = cur;
      if (ovf) ovf_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("check %s = %0h", name, act);
    end
  endtask

  // Drives one packet; tuser is only valid-looking on the first beat so a
  // DUT that samples it later would be caught.
  task automatic send_pkt(input int len, input logic [31:0] u, input logic [15:0] tag,
                          input bit expect_ok);
    word_t w;
    for (int i = 0; i < len; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = {tag, 16'h0, 32'(i)};
      s_tkeep  = (i == len - 1) ? 8'h0F : 8'hFF;
      s_tlast  = (i == len - 1);
      s_tuser  = (i == 0) ? u : ~u;
      if (expect_ok) begin
        w = '{d: s_tdata, k: s_tkeep, l: s_tlast, u: u};
        sb.push_back(w);
      end
      last_cyc = cyc;
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit toggle);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      if (toggle) m_tready = n[0] ^ n[2];
      tick();
      n++;
    end
    m_tready = 1'b1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d words left required=0", sb.size());
    end
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovf0;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;
    s_tuser = '0; m_tready = 1'b0;
    repeat (3) tick();
    chk("reset_valid", 64'(m_tvalid), 64'd0);
    chk("reset_tdata", m_tdata, 64'd0);
    chk("reset_tuser", 64'(m_tuser), 64'd0);
    chk("reset_level", 64'(level), 64'd0);
    chk("reset_drop", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single 4-word packet, latency and back-to-back output.
    m_tready = 1'b1;
    hs_cyc.delete();
    send_pkt(4, 32'hA5A5_0001, 16'h0001, 1);
    wait_drain(50, 0);
    chk("t1_words", 64'(hs_cyc.size()), 64'd4);
    if (hs_cyc.size() == 4) begin
      chk("t1_first_lat", 64'(hs_cyc[0] - last_cyc), 64'd3);
      chk("t1_last_lat", 64'(hs_cyc[3] - last_cyc), 64'd6);
    end
    chk("t1_level", 64'(level), 64'd0);

    // Oversized packet is dropped once, then a small packet passes.
    m_tready = 1'b0;
    ovf0 = ovf_pulses;
    send_pkt(20, 32'h0000_0B02, 16'h0002, 0);
    tick(); tick();
    chk("t2_drop", 64'(drop_cnt), 64'd1);
    chk("t2_ovf_pulses", 64'(ovf_pulses - ovf0), 64'd1);
    chk("t2_level", 64'(level), 64'd0);
    send_pkt(3, 32'h0000_0B03, 16'h0003, 1);
    m_tready = 1'b1;
    wait_drain(50, 0);
    chk("t2_drop_after", 64'(drop_cnt), 64'd1);

    // Fill to 15 words; a 2-word packet then has no room.
    m_tready = 1'b0;
    send_pkt(5, 32'h1111_0001, 16'h0011, 1);
    send_pkt(5, 32'h1111_0002, 16'h0012, 1);
    send_pkt(5, 32'h1111_0003, 16'h0013, 1);
    repeat (4) tick();
    chk("t3_level_full", 64'(level), 64'd15);
    send_pkt(2, 32'h1111_0004, 16'h0014, 0);
    tick(); tick();
    chk("t3_drop", 64'(drop_cnt), 64'd2);
    chk("t3_level_after_drop", 64'(level), 64'd15);
    hs_cyc.delete();
    m_tready = 1'b1;
    wait_drain(60, 0);
    chk("t3_words", 64'(hs_cyc.size()), 64'd15);
    if (hs_cyc.size() == 15) chk("t3_no_bubbles", 64'(hs_cyc[14] - hs_cyc[0]), 64'd14);
    chk("t3_level", 64'(level), 64'd0);

    // Packet FIFO full: one extra 1-word packet is dropped.
    m_tready = 1'b0;
    for (int i = 0; i < PKT_DEPTH + 1; i++)
      send_pkt(1, 32'h2222_0000 + 32'(i), 16'h0020 + 16'(i), (i < PKT_DEPTH));
    tick(); tick();
    chk("t4_drop", 64'(drop_cnt), 64'd3);
    m_tready = 1'b1;
    wait_drain(40, 0);
    chk("t4_level", 64'(level), 64'd0);

    // Irregular tready while draining two packets.
    m_tready = 1'b0;
    send_pkt(3, 32'h3333_0001, 16'h0031, 1);
    send_pkt(4, 32'h3333_0002, 16'h0032, 1);
    wait_drain(100, 1);
    chk("t5_level", 64'(level), 64'd0);

    // Reset in the middle of a packet.
    m_tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = 64'hDEAD_0000 + 64'(i);
      s_tkeep = 8'hFF; s_tuser = 32'hDEAD_BEEF;
      tick();
    end
    s_tvalid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("t6_rst_valid", 64'(m_tvalid), 64'd0);
    chk("t6_rst_level", 64'(level), 64'd0);
    chk("t6_rst_drop", 64'(drop_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send_pkt(3, 32'h4444_0001, 16'h0041, 1);
    m_tready = 1'b1;
    wait_drain(50, 0);
    chk("t6_drop", 64'(drop_cnt), 64'd0);
    chk("t6_level", 64'(level), 64'd0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
